ysyx_23060136_idu_issue_stage: RTL and testbench
================================================

# ysyx_23060136_idu_issue_stage

Parametrised decode/issue stage for the ysyx_23060136 core. It sits between the IFU and EXU and contains an N-entry register file with several write-back ports and a per-register pending-write scoreboard. RAW hazards stall the stage, and same-cycle write-back results are bypassed into the operands. A one-entry output register with valid/ready handshake feeds the EXU, and the stage supports pipeline flush.

## Interface
- XLEN, 64: register and data width.
- NREG, 32: number of architectural GPRs; RW = $clog2(NREG).
- NWB, 2: number of write-back ports.
- MAX_INFLIGHT, 3: maximum outstanding writes per register; CW = $clog2(MAX_INFLIGHT+1).
- ZERO_REG, 1: when 1, register 0 reads 0, is never written, and is never tracked.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  IFU instruction valid.
- in_ready  out  1  stage accepts instruction.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  raw instruction.
- in_rs1_en, in_rs2_en, in_rd_en  in  1 each  source/destination used (from combinational decoder).
- in_rs1, in_rs2, in_rd  in  RW each  register indices.
- out_valid  out  1  issue valid to EXU.
- out_ready  in  1  EXU accepts.
- out_pc, out_inst, out_rd, out_rd_en, out_rs1_data, out_rs2_data  out  registered copies and operands.
- wb_done  in  NWB  port i retires one tracked write (killed or real).
- wb_we  in  NWB  port i writes data (only meaningful with wb_done).
- wb_rd  in  NWB*RW  packed indices, port i at [i*RW +: RW].
- wb_data  in  NWB*XLEN  packed data.
- flush  in  1  discard the instruction held in the output register.

## Operation
- **Fire conditions.** in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- **Source readiness.** A source is ready when any of the following holds:
  - it is not enabled;
  - it is register 0 with ZERO_REG;
  - cnt[r]==0;
  - cnt[r] equals the number of wb_done ports targeting r this cycle.
- **Hazard.** Set when any enabled source is not ready, or when in_rd_en & cnt[in_rd]==MAX_INFLIGHT.
- **Accept.** in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready).
- **Operand select.** If a wb_we port writes the source register this cycle, use that port's data (highest port index wins). Otherwise use the register file.
- **Register file.**
  - Write on every wb_done & wb_we.
  - Same-rd collision across ports: highest index wins.
  - Writes to register 0 are ignored when ZERO_REG.
- **Scoreboard.**
  - cnt[r] += 1 on in_fire with in_rd_en to r (register 0 is excluded when ZERO_REG).
  - cnt[r] -= number of wb_done ports with wb_rd==r.
  - cnt[r] -= 1 on flush when out_valid & out_rd_en & out_rd==r.
  - All adjustments in one cycle are summed; the net result is applied.
  - Underflow is a downstream protocol error; an assertion fires in simulation.
- **Output register.**
  - Loads on in_fire.
  - Clears out_valid on out_fire without in_fire.
  - Holds otherwise.
- **Flush.** Forces out_valid=0 next cycle and blocks in_fire that cycle. Flushed younger instructions already downstream must still return wb_done with wb_we=0.

## Timing
- **Reset.** While rst is high, asynchronously:
  - out_valid=0, all out_* = 0;
  - all registers = 0, all cnt = 0;
  - in_ready=0.
- **Issue latency.** 1 cycle from in_fire to out_valid.
- **Write-back visibility.** A write-back is visible through the bypass in the same cycle and through the register file from the next cycle.
- **Handshake.** out_* is stable while out_valid & ~out_ready. A full register with out_ready=1 passes straight through (back-to-back issue every cycle).
- **Simultaneous events.**
  - Issue and retire of the same rd in one cycle leave cnt unchanged.
  - Flush together with out_ready=1: flush wins and the instruction is dropped.
- **Reset mid-operation.** All in-flight state is cleared; downstream must also be reset.

## Test plan
- **Reset.** Hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all cnt=0. Release -> next instruction issues with operands 0.
- **Write then read.** wb port0 writes x5=0xDEAD (done,we). Next cycle issue `add x6,x5,x5` -> out_rs1_data = out_rs2_data = 0xDEAD one cycle later.
- **RAW stall and bypass.**
  - Issue rd=x7; next instruction reads x7 -> in_ready=0 for 4 cycles.
  - Then port1 wb_done/we x7=0x1234 -> accepted that cycle with out_rs1_data=0x1234.
  - cnt[x7] returns to 0.
- **Saturation.** Issue 3 writes to x9 with no wb -> 4th write to x9 stalls; one wb_done releases it.
- **Flush.** Output holds rd=x3 with out_ready=0; assert flush -> out_valid=0 next cycle, cnt[x3]=0, a reader of x3 issues without stall.
- **Collisions.** Ports 0/1 both write x4 (0x11/0x22) -> x4=0x22. Both ports retire x8 with cnt[x8]=2 -> cnt[x8]=0 in one cycle. Writes to x0 read back 0.

Source files
------------

// File: rtl/ysyx_23060136_idu_issue_stage_if.sv
// Bundle between the IFU, the decode/issue stage, the EXU and the write-back ports.
// The slave modport is the issue stage. The master modport is everything around it.
interface ysyx_23060136_idu_issue_stage_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NWB  = 2
);
  localparam int RW = $clog2(NREG);

  // instruction in from the IFU and decoder
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_inst;
  logic              in_rs1_en;
  logic              in_rs2_en;
  logic              in_rd_en;
  logic [RW-1:0]     in_rs1;
  logic [RW-1:0]     in_rs2;
  logic [RW-1:0]     in_rd;

  // issue out to the EXU
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_inst;
  logic [RW-1:0]     out_rd;
  logic              out_rd_en;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;

  // write-back retirement ports
  logic [NWB-1:0]      wb_done;
  logic [NWB-1:0]      wb_we;
  logic [NWB*RW-1:0]   wb_rd;
  logic [NWB*XLEN-1:0] wb_data;

  // pipeline flush
  logic              flush;

  modport slave (
    input  in_valid, in_pc, in_inst, in_rs1_en, in_rs2_en, in_rd_en, in_rs1, in_rs2, in_rd,
    output in_ready,
    output out_valid, out_pc, out_inst, out_rd, out_rd_en, out_rs1_data, out_rs2_data,
    input  out_ready,
    input  wb_done, wb_we, wb_rd, wb_data,
    input  flush
  );

  modport master (
    output in_valid, in_pc, in_inst, in_rs1_en, in_rs2_en, in_rd_en, in_rs1, in_rs2, in_rd,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_rd, out_rd_en, out_rs1_data, out_rs2_data,
    output out_ready,
    output wb_done, wb_we, wb_rd, wb_data,
    output flush
  );
endinterface

// File: rtl/ysyx_23060136_idu_issue_stage.sv
// Decode/issue stage. It holds the register file and a per-register count of pending writes.
// It stalls on RAW hazards and bypasses same-cycle write-back data into the operands.
// A single output register with a valid/ready handshake feeds the EXU.
module ysyx_23060136_idu_issue_stage #(
  parameter int XLEN         = 64,
  parameter int NREG         = 32,
  parameter int NWB          = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int ZERO_REG     = 1
) (
  input logic clk,
  input logic rst,
  ysyx_23060136_idu_issue_stage_if.slave io
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  // wide enough for cnt + 1 and for NWB retirements + 1 flush, without wrap
  localparam int SW = CW + $clog2(NWB + 2) + 1;

  logic [NWB-1:0]      wb_done;
  logic [NWB-1:0]      wb_we;
  logic [NWB*RW-1:0]   wb_rd;
  logic [NWB*XLEN-1:0] wb_data;

  assign wb_done = io.wb_done;
  assign wb_we   = io.wb_we;
  assign wb_rd   = io.wb_rd;
  assign wb_data = io.wb_data;

  logic [NREG-1:0][XLEN-1:0] rf_reg;
  logic [NREG-1:0][CW-1:0]   cnt_reg;
  logic [NREG-1:0]           rf_we;
  logic [NREG-1:0][XLEN-1:0] rf_wd;
  logic [NREG-1:0][CW-1:0]   cnt_next;
  logic [NREG-1:0]           cnt_uf;

  logic              out_valid_reg;
  logic [XLEN-1:0]   out_pc_reg;
  logic [31:0]       out_inst_reg;
  logic [RW-1:0]     out_rd_reg;
  logic              out_rd_en_reg;
  logic [XLEN-1:0]   out_rs1_data_reg;
  logic [XLEN-1:0]   out_rs2_data_reg;

  function automatic logic is_zero(input logic [RW-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  // number of write-back ports that retire a write to r this cycle
  function automatic logic [SW-1:0] wb_hits(input logic [RW-1:0] r);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < NWB; i++)
      if (wb_done[i] && wb_rd[i*RW +: RW] == r) n = n + SW'(1);
    return n;
  endfunction

  // a source is usable when nothing is outstanding on it after this cycle's retirements
  function automatic logic src_ready(input logic en, input logic [RW-1:0] r);
    logic [SW-1:0] c;
    c = SW'(cnt_reg[r]);
    return !en || is_zero(r) || (c == '0) || (c == wb_hits(r));
  endfunction

  // register read with same-cycle bypass; the highest write port wins
  function automatic logic [XLEN-1:0] operand(input logic [RW-1:0] r);
    logic [XLEN-1:0] d;
    d = rf_reg[r];
    for (int i = 0; i < NWB; i++)
      if (wb_done[i] && wb_we[i] && wb_rd[i*RW +: RW] == r) d = wb_data[i*XLEN +: XLEN];
    if (is_zero(r)) d = '0;
    return d;
  endfunction

  logic hazard;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  assign hazard   = !src_ready(io.in_rs1_en, io.in_rs1) ||
                    !src_ready(io.in_rs2_en, io.in_rs2) ||
                    (io.in_rd_en && cnt_reg[io.in_rd] == CW'(MAX_INFLIGHT));
  assign in_ready = !rst && !io.flush && !hazard && (!out_valid_reg || io.out_ready);
  assign in_fire  = io.in_valid && in_ready;
  assign out_fire = out_valid_reg && io.out_ready;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    localparam logic [RW-1:0] IDX = RW'(gi);
    localparam bit TRACKED = !((ZERO_REG != 0) && (gi == 0));

    logic            we;
    logic [XLEN-1:0] wd;
    logic [SW-1:0]   plus;
    logic [SW-1:0]   minus;

    // select this register's write data; the highest port wins a collision
    always_comb begin
      we = 1'b0;
      wd = rf_reg[gi];
      for (int i = 0; i < NWB; i++)
        if (wb_done[i] && wb_we[i] && wb_rd[i*RW +: RW] == IDX) begin
          we = 1'b1;
          wd = wb_data[i*XLEN +: XLEN];
        end
      if (!TRACKED) we = 1'b0;
    end

    // sum the issue increment against the retire and flush decrements
    always_comb begin
      plus  = SW'(cnt_reg[gi]);
      minus = wb_hits(IDX);
      if (in_fire && io.in_rd_en && io.in_rd == IDX) plus = plus + SW'(1);
      if (io.flush && out_valid_reg && out_rd_en_reg && out_rd_reg == IDX) minus = minus + SW'(1);
      if (!TRACKED) begin
        plus  = '0;
        minus = '0;
      end
    end

    assign rf_we[gi]    = we;
    assign rf_wd[gi]    = wd;
    assign cnt_uf[gi]   = minus > plus;
    assign cnt_next[gi] = CW'(plus - minus);
  end

  // register file and scoreboard update; a retire with nothing pending is a protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (rf_we[r]) rf_reg[r] <= rf_wd[r];
        assert (!cnt_uf[r]);
      end
      cnt_reg <= cnt_next;
    end
  end

  // output register: load on accept, drop on consume or flush, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_pc_reg       <= '0;
      out_inst_reg     <= '0;
      out_rd_reg       <= '0;
      out_rd_en_reg    <= 1'b0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
    end else if (in_fire) begin
      out_valid_reg    <= 1'b1;
      out_pc_reg       <= io.in_pc;
      out_inst_reg     <= io.in_inst;
      out_rd_reg       <= io.in_rd;
      out_rd_en_reg    <= io.in_rd_en;
      out_rs1_data_reg <= operand(io.in_rs1);
      out_rs2_data_reg <= operand(io.in_rs2);
    end else if (out_fire || io.flush) begin
      out_valid_reg    <= 1'b0;
    end
  end

  assign io.in_ready     = in_ready;
  assign io.out_valid    = out_valid_reg;
  assign io.out_pc       = out_pc_reg;
  assign io.out_inst     = out_inst_reg;
  assign io.out_rd       = out_rd_reg;
  assign io.out_rd_en    = out_rd_en_reg;
  assign io.out_rs1_data = out_rs1_data_reg;
  assign io.out_rs2_data = out_rs2_data_reg;
endmodule

// File: tb/tb_ysyx_23060136_idu_issue_stage.sv
// Directed test of the decode/issue stage. It covers reset, the register file, RAW stall and
// bypass, scoreboard saturation, flush, write collisions, x0 and an asynchronous reset.
module tb_ysyx_23060136_idu_issue_stage;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NWB  = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060136_idu_issue_stage_if #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) bus ();

  ysyx_23060136_idu_issue_stage #(
    .XLEN(XLEN), .NREG(NREG), .NWB(NWB), .MAX_INFLIGHT(3), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.in_rs1_en = 1'b0;
    bus.in_rs2_en = 1'b0;
    bus.in_rd_en  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.wb_done   = '0;
    bus.wb_we     = '0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [31:0] inst,
                       input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2,
                       input logic rde, input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.in_rs1_en = r1e;
    bus.in_rs1    = r1;
    bus.in_rs2_en = r2e;
    bus.in_rs2    = r2;
    bus.in_rd_en  = rde;
    bus.in_rd     = rd;
    $display("issue pc=0x%0h rs1=%0d(%0b) rs2=%0d(%0b) rd=%0d(%0b)", pc, r1, r1e, r2, r2e, rd, rde);
  endtask

  task automatic wb(input int port, input logic we, input logic [4:0] rd, input logic [63:0] data);
    bus.wb_done[port]           = 1'b1;
    bus.wb_we[port]             = we;
    bus.wb_rd[port*5 +: 5]      = rd;
    bus.wb_data[port*64 +: 64]  = data;
    $display("wb port=%0d we=%0b rd=%0d data=0x%0h", port, we, rd, data);
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // reset held for 3 cycles with an instruction offered
    issue(64'h8000_0000, 32'h0000_0093, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1);
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_pc", bus.out_pc, 64'h0);
    chk("rst_cnt1", dut.cnt_reg[1], 2'd0);

    // first instruction after reset: reads x1,x2 (zero), writes x5
    rst = 1'b0;
    issue(64'h8000_0004, 32'h0020_82b3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5);
    #1 chk("post_rst_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("post_rst_out_valid", bus.out_valid, 1'b1);
    chk("post_rst_out_pc", bus.out_pc, 64'h8000_0004);
    chk("post_rst_rs1", bus.out_rs1_data, 64'h0);
    chk("post_rst_rs2", bus.out_rs2_data, 64'h0);
    chk("cnt5_pending", dut.cnt_reg[5], 2'd1);

    // x5 = 0xDEAD via port 0, then add x6,x5,x5 reads it from the register file
    idle();
    wb(0, 1'b1, 5'd5, 64'hDEAD);
    tick();
    idle();
    chk("drain_out_valid", bus.out_valid, 1'b0);
    chk("cnt5_retired", dut.cnt_reg[5], 2'd0);
    issue(64'h8000_0008, 32'h0052_8333, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6);
    #1 chk("add_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("add_rs1", bus.out_rs1_data, 64'hDEAD);
    chk("add_rs2", bus.out_rs2_data, 64'hDEAD);
    chk("add_rd", bus.out_rd, 5'd6);
    chk("cnt6_pending", dut.cnt_reg[6], 2'd1);

    // RAW: write x7, then a reader of x7 stalls until port 1 writes it back
    issue(64'h8000_000c, 32'h0000_0393, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    chk("cnt7_pending", dut.cnt_reg[7], 2'd1);
    issue(64'h8000_0010, 32'h0003_8413, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int c = 0; c < 4; c++) begin
      #1 chk("raw_stall", bus.in_ready, 1'b0);
      tick();
    end
    wb(1, 1'b1, 5'd7, 64'h1234);
    wb(0, 1'b0, 5'd6, 64'hBAD0);
    #1 chk("raw_release", bus.in_ready, 1'b1);
    tick();
    idle();
    chk("raw_bypass_rs1", bus.out_rs1_data, 64'h1234);
    chk("raw_out_pc", bus.out_pc, 64'h8000_0010);
    chk("cnt7_cleared", dut.cnt_reg[7], 2'd0);
    chk("cnt6_killed", dut.cnt_reg[6], 2'd0);
    chk("rf7", dut.rf_reg[7], 64'h1234);

    // saturation on x9: three issued, fourth stalls until one retires
    for (int k = 0; k < 3; k++) begin
      issue(64'h8000_0100 + 64'(k * 4), 32'h0000_0493, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
      #1 chk("sat_accept", bus.in_ready, 1'b1);
      tick();
    end
    chk("cnt9_full", dut.cnt_reg[9], 2'd3);
    issue(64'h8000_010c, 32'h0000_0493, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    #1 chk("sat_stall", bus.in_ready, 1'b0);
    wb(0, 1'b0, 5'd9, 64'h0);
    #1 chk("sat_stall_wb_cycle", bus.in_ready, 1'b0);
    tick();
    bus.wb_done = '0;
    chk("cnt9_after_wb", dut.cnt_reg[9], 2'd2);
    #1 chk("sat_release", bus.in_ready, 1'b1);
    tick();
    idle();
    chk("cnt9_refill", dut.cnt_reg[9], 2'd3);
    wb(0, 1'b0, 5'd9, 64'h0);
    tick();
    idle();
    chk("cnt9_two", dut.cnt_reg[9], 2'd2);
    wb(0, 1'b0, 5'd9, 64'h0);
    wb(1, 1'b0, 5'd9, 64'h0);
    tick();
    idle();
    chk("cnt9_dual_retire", dut.cnt_reg[9], 2'd0);

    // flush: hold rd=x3 with out_ready low, flush it, then a reader of x3 goes straight through
    bus.out_ready = 1'b0;
    issue(64'h8000_0200, 32'h0000_0193, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    tick();
    idle();
    chk("fl_out_valid", bus.out_valid, 1'b1);
    chk("cnt3_pending", dut.cnt_reg[3], 2'd1);
    tick();
    chk("fl_hold_valid", bus.out_valid, 1'b1);
    chk("fl_hold_pc", bus.out_pc, 64'h8000_0200);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    issue(64'h8000_0204, 32'h0001_8213, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk("fl_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk("fl_dropped", bus.out_valid, 1'b0);
    chk("cnt3_flushed", dut.cnt_reg[3], 2'd0);
    #1 chk("fl_reader_ready", bus.in_ready, 1'b1);
    tick();
    idle();
    chk("fl_reader_issued", bus.out_valid, 1'b1);
    chk("fl_reader_pc", bus.out_pc, 64'h8000_0204);

    // collision: two writes to x4 pending, both ports write it, reader sees port 1
    issue(64'h8000_0300, 32'h0000_0213, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);
    tick();
    tick();
    idle();
    chk("cnt4_two", dut.cnt_reg[4], 2'd2);
    wb(0, 1'b1, 5'd4, 64'h11);
    wb(1, 1'b1, 5'd4, 64'h22);
    issue(64'h8000_0308, 32'h0042_0533, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0);
    #1 chk("col_ready", bus.in_ready, 1'b1);
    tick();
    idle();
    chk("col_bypass", bus.out_rs1_data, 64'h22);
    chk("cnt4_cleared", dut.cnt_reg[4], 2'd0);
    issue(64'h8000_030c, 32'h0042_0533, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    idle();
    chk("col_rf", bus.out_rs1_data, 64'h22);

    // x0: untracked, write ignored, bypass and register file both read zero
    wb(0, 1'b1, 5'd0, 64'hFF);
    issue(64'h8000_0400, 32'h0000_0013, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    idle();
    chk("x0_bypass", bus.out_rs1_data, 64'h0);
    chk("x0_cnt", dut.cnt_reg[0], 2'd0);
    issue(64'h8000_0404, 32'h0000_0013, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    idle();
    chk("x0_rf", bus.out_rs1_data, 64'h0);

    // asynchronous reset mid-operation
    issue(64'h8000_0500, 32'h0000_0513, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10);
    tick();
    idle();
    chk("cnt10_pending", dut.cnt_reg[10], 2'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_cnt10", dut.cnt_reg[10], 2'd0);
    chk("arst_rf5", dut.rf_reg[5], 64'h0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
